// File: rtl/ram_arb_pkg.sv
// Shared widths and enumerations for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes plus the RAM read/write ports driven by the arbiter.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              reqA;
    logic              reqB;
    logic              wrA;
    logic              wrB;
    logic [ADDR_W-1:0] addrA;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic              ackA;
    logic              ackB;
    logic [DATA_W-1:0] rdataA;
    logic [DATA_W-1:0] rdataB;

    logic              writeEnable;
    logic [ADDR_W-1:0] writeAddress;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] readAddress1;
    logic [ADDR_W-1:0] readAddress2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;

    // Requesters and the RAM side together.
    modport master (
        output reqA, reqB, wrA, wrB, addrA, addrB, dataA, dataB,
        output readData1, readData2,
        input  ackA, ackB, rdataA, rdataB,
        input  writeEnable, writeAddress, writeData, readAddress1, readAddress2
    );

    // The arbiter.
    modport slave (
        input  reqA, reqB, wrA, wrB, addrA, addrB, dataA, dataB,
        input  readData1, readData2,
        output ackA, ackB, rdataA, rdataB,
        output writeEnable, writeAddress, writeData, readAddress1, readAddress2
    );

endinterface

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic    reqA,
    input  logic    reqB,
    input  req_id_e lastServed,
    output req_id_e grant
);

    always_comb begin
        grant = REQ_A;
        if (reqA && reqB) begin
            grant = (lastServed == REQ_A) ? REQ_B : REQ_A;
        end else if (reqB) begin
            grant = REQ_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto a single-write/dual-read RAM, one op per three cycles.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic          clock,
    input  logic          resetN,
    ram_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    req_id_e           grant, grant_q, last_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] raddr1_q, raddr2_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic              any_req;

    assign any_req = bus.reqA | bus.reqB;

    rr_grant2 u_grant (
        .reqA       (bus.reqA),
        .reqB       (bus.reqB),
        .lastServed (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q   <= IDLE;
            grant_q   <= REQ_A;
            last_q    <= REQ_B;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q <= grant;
                last_q  <= grant;
                if (grant == REQ_A) begin
                    wr_q     <= bus.wrA;
                    addr_q   <= bus.addrA;
                    data_q   <= bus.dataA;
                    raddr1_q <= bus.addrA;
                end else begin
                    wr_q     <= bus.wrB;
                    addr_q   <= bus.addrB;
                    data_q   <= bus.dataB;
                    raddr2_q <= bus.addrB;
                end
            end
            // Captured on the same edge the write lands, so writes return the old word.
            if (state_q == ACCESS) begin
                if (grant_q == REQ_A) begin
                    rdata_a_q <= bus.readData1;
                end else begin
                    rdata_b_q <= bus.readData2;
                end
            end
        end
    end

    // Gating with resetN aborts a write whose ACCESS cycle coincides with reset.
    assign bus.writeEnable  = (state_q == ACCESS) && wr_q && resetN;
    assign bus.writeAddress = addr_q;
    assign bus.writeData    = data_q;
    assign bus.readAddress1 = raddr1_q;
    assign bus.readAddress2 = raddr2_q;
    assign bus.ackA         = (state_q == RESP) && (grant_q == REQ_A);
    assign bus.ackB         = (state_q == RESP) && (grant_q == REQ_B);
    assign bus.rdataA       = rdata_a_q;
    assign bus.rdataB       = rdata_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a transaction-timeline reference model and a RAM.
module tb_ram_arbiter;

    logic clock = 1'b0;
    logic resetN = 1'b0;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] ramMemory [16] = '{default: 8'h00};

    always @(posedge clock) begin
        if (bus.writeEnable) ramMemory[bus.writeAddress] <= bus.writeData;
    end
    assign bus.readData1 = ramMemory[bus.readAddress1];
    assign bus.readData2 = ramMemory[bus.readAddress2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: an accepted op occupies one access cycle then one response cycle.
    int         cyc = 0;
    bit         model_valid = 1'b0;
    int         m_age = -1;
    bit         m_b = 1'b0;
    bit         m_wr = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_data = '0;
    bit         m_last_b = 1'b1;
    logic [7:0] m_rd_a = '0;
    logic [7:0] m_rd_b = '0;
    logic [3:0] m_ra1 = '0;
    logic [3:0] m_ra2 = '0;
    logic [7:0] m_mem [16] = '{default: 8'h00};
    bit         m_pick_b;

    assign m_pick_b = (bus.reqA && bus.reqB) ? !m_last_b : !bus.reqA;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!resetN) begin
            model_valid <= 1'b1;
            m_age       <= -1;
            m_last_b    <= 1'b1;
            m_rd_a      <= '0;
            m_rd_b      <= '0;
            m_ra1       <= '0;
            m_ra2       <= '0;
            m_wr        <= 1'b0;
            m_addr      <= '0;
            m_data      <= '0;
        end else if (m_age < 0) begin
            if (bus.reqA || bus.reqB) begin
                m_age    <= 0;
                m_b      <= m_pick_b;
                m_last_b <= m_pick_b;
                m_wr     <= m_pick_b ? bus.wrB : bus.wrA;
                m_addr   <= m_pick_b ? bus.addrB : bus.addrA;
                m_data   <= m_pick_b ? bus.dataB : bus.dataA;
                if (m_pick_b) m_ra2 <= bus.addrB;
                else          m_ra1 <= bus.addrA;
            end
        end else if (m_age == 0) begin
            if (m_b) m_rd_b <= m_mem[m_addr];
            else     m_rd_a <= m_mem[m_addr];
            if (m_wr) m_mem[m_addr] <= m_data;
            m_age <= 1;
        end else begin
            m_age <= -1;
        end
    end

    typedef struct {
        bit is_b;
        int cyc;
    } ack_rec_t;
    ack_rec_t ack_log [$];

    always @(negedge clock) begin
        if (model_valid) begin
            bit exp_we;
            bit mem_ok;
            exp_we = (m_age == 0) && m_wr && resetN;
            chk("ackA", 32'(bus.ackA), 32'((m_age == 1) && !m_b));
            chk("ackB", 32'(bus.ackB), 32'((m_age == 1) && m_b));
            chk("ack_exclusive", 32'(bus.ackA & bus.ackB), 32'h0);
            chk("writeEnable", 32'(bus.writeEnable), 32'(exp_we));
            if (exp_we) begin
                chk("writeAddress", 32'(bus.writeAddress), 32'(m_addr));
                chk("writeData", 32'(bus.writeData), 32'(m_data));
            end
            chk("rdataA", 32'(bus.rdataA), 32'(m_rd_a));
            chk("rdataB", 32'(bus.rdataB), 32'(m_rd_b));
            chk("readAddress1", 32'(bus.readAddress1), 32'(m_ra1));
            chk("readAddress2", 32'(bus.readAddress2), 32'(m_ra2));
            mem_ok = 1'b1;
            for (int i = 0; i < 16; i++) if (ramMemory[i] !== m_mem[i]) mem_ok = 1'b0;
            chk("ram_contents", 32'(mem_ok), 32'h1);
            if (bus.ackA) ack_log.push_back('{is_b: 1'b0, cyc: cyc});
            if (bus.ackB) ack_log.push_back('{is_b: 1'b1, cyc: cyc});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetN   = 1'b0;
        bus.reqA = 1'b0;
        bus.reqB = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic wait_ack(input bit is_b, input string nm, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            lat++;
            if (is_b ? bus.ackB : bus.ackA) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s ack_timeout actual=none required=ack", nm);
        end
    endtask

    task automatic op_a(input bit wr, input logic [3:0] addr, input logic [7:0] data,
                        output int lat);
        bus.reqA  = 1'b1;
        bus.wrA   = wr;
        bus.addrA = addr;
        bus.dataA = data;
        wait_ack(1'b0, "op_a", lat);
        bus.reqA = 1'b0;
        bus.wrA  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        logic [7:0] pre;
        logic [7:0] hold_a, hold_b;

        bus.reqA = 1'b0; bus.reqB = 1'b0;
        bus.wrA = 1'b0;  bus.wrB = 1'b0;
        bus.addrA = '0;  bus.addrB = '0;
        bus.dataA = '0;  bus.dataB = '0;

        // Reset state
        do_reset();
        chk("rst_ackA", 32'(bus.ackA), 32'h0);
        chk("rst_ackB", 32'(bus.ackB), 32'h0);
        chk("rst_we", 32'(bus.writeEnable), 32'h0);
        chk("rst_rdataA", 32'(bus.rdataA), 32'h00);
        chk("rst_rdataB", 32'(bus.rdataB), 32'h00);
        chk("rst_raddr1", 32'(bus.readAddress1), 32'h0);
        chk("rst_raddr2", 32'(bus.readAddress2), 32'h0);

        // A write of 0x01 to address 0
        op_a(1'b1, 4'd0, 8'h01, lat);
        chk("a_write_latency", 32'(lat), 32'd2);
        chk("a_write_rdata", 32'(bus.rdataA), 32'h00);
        chk("a_write_mem0", 32'(ramMemory[0]), 32'h01);
        tick();

        // Tie at address 1: A writes 0x04, B reads
        do_reset();
        bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 4'd1; bus.dataA = 8'h04;
        bus.reqB = 1'b1; bus.wrB = 1'b0; bus.addrB = 4'd1; bus.dataB = 8'h00;
        wait_ack(1'b0, "tie_a", lat);
        chk("tie_a_latency", 32'(lat), 32'd2);
        chk("tie_b_not_yet", 32'(bus.ackB), 32'h0);
        bus.reqA = 1'b0; bus.wrA = 1'b0;
        wait_ack(1'b1, "tie_b", lat);
        chk("tie_b_spacing", 32'(lat), 32'd3);
        chk("tie_b_rdata", 32'(bus.rdataB), 32'h04);
        bus.reqB = 1'b0;
        tick();

        // Both held high through four operations
        ack_log.delete();
        bus.reqA = 1'b1; bus.wrA = 1'b0; bus.addrA = 4'd1;
        bus.reqB = 1'b1; bus.wrB = 1'b0; bus.addrB = 4'd0;
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            tick();
            if (bus.ackA || bus.ackB) n++;
        end
        chk("rr_op_count", 32'(n), 32'd4);
        bus.reqA = 1'b0; bus.reqB = 1'b0;
        tick();
        chk("rr_log_size", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            chk("rr_order0", 32'(ack_log[0].is_b), 32'h0);
            chk("rr_order1", 32'(ack_log[1].is_b), 32'h1);
            chk("rr_order2", 32'(ack_log[2].is_b), 32'h0);
            chk("rr_order3", 32'(ack_log[3].is_b), 32'h1);
            for (int i = 1; i < 4; i++)
                chk("rr_spacing", 32'(ack_log[i].cyc - ack_log[i-1].cyc), 32'd3);
        end
        chk("rr_rdataA", 32'(bus.rdataA), 32'h04);
        chk("rr_rdataB", 32'(bus.rdataB), 32'h01);

        // Read-after-write and write returning the pre-write word
        op_a(1'b1, 4'd4, 8'hAA, lat);
        tick();
        op_a(1'b0, 4'd4, 8'h00, lat);
        chk("raw_rdataA", 32'(bus.rdataA), 32'hAA);
        tick();
        op_a(1'b1, 4'd4, 8'hBB, lat);
        chk("war_rdataA", 32'(bus.rdataA), 32'hAA);
        chk("war_mem4", 32'(ramMemory[4]), 32'hBB);
        tick();

        // Reset landing on the ACCESS cycle of a write
        pre = ramMemory[2];
        bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 4'd2; bus.dataA = 8'hFF;
        tick();
        chk("abort_we_before", 32'(bus.writeEnable), 32'h1);
        resetN   = 1'b0;
        bus.reqA = 1'b0;
        #1;
        chk("abort_we_gated", 32'(bus.writeEnable), 32'h0);
        tick();
        chk("abort_mem2", 32'(ramMemory[2]), 32'(pre));
        chk("abort_ackA", 32'(bus.ackA), 32'h0);
        chk("abort_rdataA", 32'(bus.rdataA), 32'h00);
        chk("abort_rdataB", 32'(bus.rdataB), 32'h00);
        chk("abort_raddr1", 32'(bus.readAddress1), 32'h0);
        chk("abort_waddr", 32'(bus.writeAddress), 32'h0);
        chk("abort_wdata", 32'(bus.writeData), 32'h00);
        resetN = 1'b1;
        tick();
        tick();
        chk("abort_no_late_ack", 32'(bus.ackA), 32'h0);

        // Give the outputs non-reset values, then idle for ten cycles
        op_a(1'b0, 4'd1, 8'h00, lat);
        tick();
        hold_a = bus.rdataA;
        hold_b = bus.rdataB;
        chk("idle_setup_rdataA", 32'(hold_a), 32'h04);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_we", 32'(bus.writeEnable), 32'h0);
            chk("idle_acks", 32'(bus.ackA | bus.ackB), 32'h0);
            chk("idle_rdataA", 32'(bus.rdataA), 32'(hold_a));
            chk("idle_rdataB", 32'(bus.rdataB), 32'(hold_b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
